// File: rtl/hit_pkg.sv
// Shared definitions for the hit serial receiver and the downstream decoder:
// FSM state encoding, error codes and default field widths.
package hit_pkg;

  localparam int HIT_ADDR_W = 2;
  localparam int HIT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    DONE     = 2'd2,
    WAIT_END = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/hit_serial_rx_if.sv
// Serial command input and decoded word / error outputs of hit_serial_rx.
// The slave modport is the receiver; master is the stream source and word consumer.
interface hit_serial_rx_if
  import hit_pkg::*;
#(
  parameter int ADDR_W = HIT_ADDR_W,
  parameter int DATA_W = HIT_DATA_W
) ();

  // Handshake: ser_din is taken on any cycle with ser_bit_vld high while ser_en
  // frames the command; valid is a one-cycle pulse with no ready, so the consumer
  // must take address/data in that cycle.
  logic              ser_en;
  logic              ser_bit_vld;
  logic              ser_din;
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              frame_err;
  logic [1:0]        err_code;
  state_e            state_dbg;

  modport slave (
    input  ser_en, ser_bit_vld, ser_din,
    output valid, address, data, busy, frame_err, err_code, state_dbg
  );

  modport master (
    output ser_en, ser_bit_vld, ser_din,
    input  valid, address, data, busy, frame_err, err_code, state_dbg
  );

endinterface

// File: rtl/hit_rx_timeout.sv
// Inter-strobe watchdog: counts idle cycles, cleared by clr, flags expiry
// once the count reaches TIMEOUT_CYC-1.
module hit_rx_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hit_serial_rx.sv
// Deserializes framed, bit-strobed commands into {address, data} with error reporting.
// Optional trailing even-parity bit enabled by defining HIT_RX_PARITY_EN.
module hit_serial_rx
  import hit_pkg::*;
#(
  parameter int ADDR_W      = HIT_ADDR_W,
  parameter int DATA_W      = HIT_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  hit_serial_rx_if.slave  bus
);

  localparam int F = ADDR_W + DATA_W;
`ifdef HIT_RX_PARITY_EN
  localparam int F_TOT = F + 1;
`else
  localparam int F_TOT = F;
`endif
  localparam int BCW = $clog2(F_TOT + 1);

  state_e            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [F_TOT-1:0]  shift_q, shift_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ferr_q, ferr_d;
  logic [1:0]        ecode_q, ecode_d;

  logic              tmo_clr, tmo_inc, tmo_expired;
  logic [F_TOT-1:0]  shift_nxt;
  logic [BCW-1:0]    bit_nxt;
  logic [F-1:0]      payload;
  logic              frame_ok;

  hit_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  assign shift_nxt = {shift_q[F_TOT-2:0], bus.ser_din};
  assign bit_nxt   = bit_cnt_q + 1'b1;

`ifdef HIT_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign frame_ok = ~^shift_nxt;
  assign payload  = shift_nxt[F_TOT-1:1];
`else
  assign frame_ok = 1'b1;
  assign payload  = shift_nxt;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    ferr_d    = 1'b0;
    ecode_d   = ecode_q;
    tmo_clr   = 1'b1;
    tmo_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ser_en) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
          if (bus.ser_bit_vld) begin
            shift_d   = {{(F_TOT-1){1'b0}}, bus.ser_din};
            bit_cnt_d = BCW'(1);
          end
        end
      end

      SHIFT: begin
        tmo_clr = bus.ser_bit_vld;
        tmo_inc = !bus.ser_bit_vld;
        // The last bit completes the frame even if ser_en drops in the same cycle.
        if (bus.ser_bit_vld && (bit_nxt == BCW'(F_TOT))) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_nxt;
          if (frame_ok) begin
            valid_d = 1'b1;
            addr_d  = payload[F-1 -: ADDR_W];
            data_d  = payload[DATA_W-1:0];
            state_d = DONE;
          end else begin
            ferr_d  = 1'b1;
            ecode_d = ERR_OVERRUN;
            state_d = bus.ser_en ? WAIT_END : IDLE;
          end
        end else if (!bus.ser_en) begin
          ferr_d  = 1'b1;
          ecode_d = ERR_SHORT;
          state_d = IDLE;
        end else if (bus.ser_bit_vld) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_nxt;
        end else if (tmo_expired) begin
          ferr_d  = 1'b1;
          ecode_d = ERR_TIMEOUT;
          state_d = WAIT_END;
        end
      end

      DONE: begin
        state_d = bus.ser_en ? WAIT_END : IDLE;
      end

      WAIT_END: begin
        if (bus.ser_bit_vld) begin
          ferr_d  = 1'b1;
          ecode_d = ERR_OVERRUN;
        end
        if (!bus.ser_en) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      ferr_q    <= 1'b0;
      ecode_q   <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
      ecode_q   <= ecode_d;
    end
  end

  assign bus.valid     = valid_q;
  assign bus.address   = addr_q;
  assign bus.data      = data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_err = ferr_q;
  assign bus.err_code  = ecode_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_hit_serial_rx.sv
// Directed bench for hit_serial_rx: normal frame, short frame, timeout, overrun,
// async reset mid-frame and (with HIT_RX_PARITY_EN) parity accept/reject.
module tb_hit_serial_rx;
  import hit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   valid_cnt;
  int   err_cnt;
  logic both_seen;

  hit_serial_rx_if bus ();

  hit_serial_rx #(.TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.valid === 1'b1)     valid_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic b);
    bus.ser_bit_vld = 1'b1;
    bus.ser_din     = b;
    @(posedge clk);
    #1;
    bus.ser_bit_vld = 1'b0;
    bus.ser_din     = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      strobe(w[i]);
      if (i != 0) idle(gap - 1);
    end
  endtask

  // Full frame, with a correct even-parity bit appended in the parity build.
  task automatic send_frame(input logic [1:0] a, input logic [15:0] d, input int gap);
`ifdef HIT_RX_PARITY_EN
    send_bits({13'd0, a, d, ^{a, d}}, 19, gap);
`else
    send_bits({14'd0, a, d}, 18, gap);
`endif
  endtask

  initial begin
    int v0;
    int e0;
    n_assert  = 0;
    n_fail    = 0;
    valid_cnt = 0;
    err_cnt   = 0;
    both_seen = 1'b0;
    rst_n           = 1'b0;
    bus.ser_en      = 1'b0;
    bus.ser_bit_vld = 1'b0;
    bus.ser_din     = 1'b0;
    idle(3);
    check("rst_valid", bus.valid, 0);
    check("rst_addr", bus.address, 0);
    check("rst_data", bus.data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ecode", bus.err_code, 0);
    check("rst_state", bus.state_dbg, IDLE);
    rst_n = 1'b1;
    idle(2);

    // Normal frame, one strobe every 3 cycles; first strobe with ser_en rise.
    v0 = valid_cnt;
    bus.ser_en = 1'b1;
    send_frame(2'b01, 16'hA5C3, 3);
    check("t1_valid", bus.valid, 1);
    check("t1_addr", bus.address, 2'd1);
    check("t1_data", bus.data, 16'hA5C3);
    check("t1_ferr", bus.frame_err, 0);
    check("t1_busy", bus.busy, 1);
    bus.ser_en = 1'b0;
    idle(1);
    check("t1_valid_drop", bus.valid, 0);
    check("t1_busy_drop", bus.busy, 0);
    check("t1_hold_data", bus.data, 16'hA5C3);
    check("t1_pulses", valid_cnt - v0, 1);

    // Short frame: ser_en drops after 10 bits.
    idle(2);
    v0 = valid_cnt;
    bus.ser_en = 1'b1;
    send_bits(32'h2B5, 10, 2);
    idle(1);
    bus.ser_en = 1'b0;
    idle(1);
    check("t2_ferr", bus.frame_err, 1);
    check("t2_ecode", bus.err_code, ERR_SHORT);
    check("t2_valid", bus.valid, 0);
    check("t2_busy", bus.busy, 0);
    idle(1);
    check("t2_ferr_pulse", bus.frame_err, 0);
    check("t2_ecode_hold", bus.err_code, ERR_SHORT);
    check("t2_no_valid", valid_cnt - v0, 0);

    // Timeout: 5 bits then silence with ser_en high, TIMEOUT_CYC=16.
    idle(2);
    v0 = valid_cnt;
    bus.ser_en = 1'b1;
    send_bits(32'h15, 5, 2);
    idle(15);
    check("t3_ferr_early", bus.frame_err, 0);
    idle(1);
    check("t3_ferr", bus.frame_err, 1);
    check("t3_ecode", bus.err_code, ERR_TIMEOUT);
    check("t3_state", bus.state_dbg, WAIT_END);
    idle(1);
    check("t3_ferr_pulse", bus.frame_err, 0);
    check("t3_busy", bus.busy, 1);
    bus.ser_en = 1'b0;
    idle(1);
    check("t3_idle", bus.busy, 0);
    check("t3_no_valid", valid_cnt - v0, 0);

    // Back-to-back full frame then two extra strobes.
    idle(2);
    v0 = valid_cnt;
    bus.ser_en = 1'b1;
    send_frame(2'b11, 16'hFFFF, 1);
    check("t4_valid", bus.valid, 1);
    check("t4_addr", bus.address, 2'd3);
    check("t4_data", bus.data, 16'hFFFF);
    idle(2);
    check("t4_state", bus.state_dbg, WAIT_END);
    e0 = err_cnt;
    strobe(1'b1);
    check("t4_ovr1", bus.frame_err, 1);
    check("t4_ovr1_code", bus.err_code, ERR_OVERRUN);
    check("t4_ovr1_valid", bus.valid, 0);
    idle(1);
    check("t4_ovr_gap", bus.frame_err, 0);
    strobe(1'b0);
    check("t4_ovr2", bus.frame_err, 1);
    check("t4_ovr2_code", bus.err_code, ERR_OVERRUN);
    idle(1);
    bus.ser_en = 1'b0;
    idle(1);
    check("t4_idle", bus.busy, 0);
    check("t4_valid_pulses", valid_cnt - v0, 1);
    check("t4_err_pulses", err_cnt - e0, 2);

    // Asynchronous reset mid-frame at bit 9, then a clean frame.
    idle(2);
    bus.ser_en = 1'b1;
    send_bits(32'h1A5, 9, 2);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", bus.busy, 0);
    check("t5_valid", bus.valid, 0);
    check("t5_addr", bus.address, 0);
    check("t5_data", bus.data, 0);
    check("t5_ecode", bus.err_code, 0);
    check("t5_ferr", bus.frame_err, 0);
    bus.ser_en = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    v0 = valid_cnt;
    e0 = err_cnt;
    bus.ser_en = 1'b1;
    send_frame(2'b10, 16'h1234, 2);
    check("t5_new_valid", bus.valid, 1);
    check("t5_new_addr", bus.address, 2'd2);
    check("t5_new_data", bus.data, 16'h1234);
    bus.ser_en = 1'b0;
    idle(2);
    check("t5_pulses", valid_cnt - v0, 1);
    check("t5_no_err", err_cnt - e0, 0);

`ifdef HIT_RX_PARITY_EN
    // 2'b10 + 16'h0001 has two ones, so the even-parity bit is 0.
    idle(2);
    bus.ser_en = 1'b1;
    send_bits({13'd0, 2'b10, 16'h0001, 1'b0}, 19, 2);
    check("t6_par_valid", bus.valid, 1);
    check("t6_par_addr", bus.address, 2'd2);
    check("t6_par_data", bus.data, 16'h0001);
    bus.ser_en = 1'b0;
    idle(2);
    v0 = valid_cnt;
    bus.ser_en = 1'b1;
    send_bits({13'd0, 2'b10, 16'h0001, 1'b1}, 19, 2);
    check("t6_bad_valid", bus.valid, 0);
    check("t6_bad_ferr", bus.frame_err, 1);
    check("t6_bad_ecode", bus.err_code, ERR_OVERRUN);
    check("t6_bad_state", bus.state_dbg, WAIT_END);
    bus.ser_en = 1'b0;
    idle(2);
    check("t6_bad_no_valid", valid_cnt - v0, 0);
    check("t6_bad_idle", bus.busy, 0);
`endif

    check("valid_ferr_exclusive", both_seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_serial_rx.md
Name: hit_serial_rx

Overview:
- Upstream stage of the hit configuration decoder.
- Deserializes a framed, bit-strobed serial command stream into a parallel {address, data} word.
- Presents the word as a single-cycle valid pulse to the decoder's valid/address/data inputs.
- Detects short frames, stalled frames and overrun bits, and reports them through an error pulse and code.

Parameters:
- ADDR_W, 2, address field width in bits.
- DATA_W, 16, data field width in bits.
- TIMEOUT_CYC, 1024, maximum clk cycles allowed between bit strobes inside a frame; must be >= 2.

Ports:
- clk  input  1  single block clock.
- rst_n  input  1  asynchronous active-low reset.
- ser_en  input  1  frame enable; high for the whole frame.
- ser_bit_vld  input  1  one-cycle strobe; ser_din is sampled when high.
- ser_din  input  1  serial data bit, MSB first.
- valid  output  1  one-cycle pulse; address/data hold a complete frame.
- address  output  ADDR_W  decoded address field.
- data  output  DATA_W  decoded data field.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle error pulse.
- err_code  output  2  error cause, updated with frame_err: 1 short, 2 timeout, 3 overrun/parity; holds its value until the next error.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: valid=0, address=0, data=0, busy=0, frame_err=0, err_code=0, state=IDLE, bit counter=0, timeout counter=0, shift register=0.
- Frame format (F = ADDR_W+DATA_W, 18 bits by default): the first ADDR_W bits are address, MSB first, then DATA_W data bits, MSB first.
- FSM states: IDLE, SHIFT, DONE, WAIT_END.
- IDLE:
  - ser_en=1 -> SHIFT; bit counter and timeout counter cleared.
  - A ser_bit_vld in the same cycle that ser_en first rises is sampled as bit 0.
- SHIFT:
  - Each cycle with ser_bit_vld=1: shift ser_din into the LSB, increment the bit counter, clear the timeout counter.
  - Otherwise the timeout counter increments.
  - When bit F is sampled -> DONE.
  - ser_en=0 before F bits: frame_err=1 and err_code=1 for one cycle, frame discarded -> IDLE.
  - Timeout counter reaches TIMEOUT_CYC-1 with no strobe: frame_err=1, err_code=2, frame discarded -> WAIT_END.
  - If ser_en falls in the same cycle that the last bit is sampled, the frame is complete; it is not a short frame.
- DONE (one cycle):
  - valid=1; address/data are loaded from the shift register.
  - Latency: valid is high in the cycle after the clk edge that samples the last bit.
  - Then ser_en=1 -> WAIT_END; ser_en=0 -> IDLE.
  - address/data hold their values until the next valid.
- WAIT_END:
  - Wait for ser_en=0 -> IDLE.
  - Any ser_bit_vld here: frame_err=1, err_code=3, one pulse per extra bit; the bit is ignored and no second valid is produced.
- Address 0 is forwarded unchanged; filtering address 0 is the downstream decoder's job.
- No back-pressure: the downstream stage accepts valid in any cycle.
- Reset mid-frame: everything returns immediately to reset values; the partial frame is lost and no valid or error is emitted.
- valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: HIT_RX_PARITY_EN.
- Defined:
  - Frame is F+1 bits; the final bit is even parity over the preceding F bits.
  - Parity match: normal DONE/valid.
  - Mismatch: no valid, frame_err=1, err_code=3, -> WAIT_END if ser_en=1, else IDLE.
- Not defined: frame is exactly F bits and no parity logic is present.

Decomposition:
- Shared package hit_pkg holds:
  - state enum typedef (IDLE/SHIFT/DONE/WAIT_END);
  - err_code localparams ERR_NONE=0, ERR_SHORT=1, ERR_TIMEOUT=2, ERR_OVERRUN=3;
  - default ADDR_W/DATA_W constants shared with the decoder.
- One natural sub-module: hit_rx_timeout, a loadable/clearable counter with an expiry flag parameterised by TIMEOUT_CYC.

Test Plan:
- 18-bit frame 2'b01 + 16'hA5C3, one bit per 3 cycles -> single valid pulse; address=1, data=16'hA5C3; 1 cycle after the last strobe; busy falls after ser_en drops.
- ser_en dropped after 10 bits -> frame_err pulse, err_code=1, no valid, return to IDLE.
- Strobes stopped after 5 bits with ser_en held high, TIMEOUT_CYC=16 -> frame_err 16 cycles after the last strobe, err_code=2, no valid; ser_en low -> IDLE.
- Full frame 2'b11 + 16'hFFFF followed by 2 extra strobes -> one valid (address=3, data=16'hFFFF), then two frame_err pulses with err_code=3.
- rst_n asserted asynchronously mid-frame at bit 9 -> all outputs 0 immediately; a new full frame after reset decodes correctly.
- HIT_RX_PARITY_EN defined, 19-bit frame:
  - correct parity for 2'b10 + 16'h0001 -> valid;
  - parity bit flipped -> no valid, err_code=3.
